display_bcd_feeder: RTL and testbench

Memory-mapped digit source for the VGA eight-digit display stage. The CPU writes a 32-bit value and a display mode over the MMIO bus. The block converts the value into eight 4-bit digit codes s1..s8 and drives them straight into the vga display module's digit inputs. Hex mode is a direct nibble split. Decimal mode uses a sequential shift-add-3 (double-dabble) converter, and the outputs update atomically when the conversion finishes.

---
 rtl/display_bcd_feeder_if.sv | 30 +++
 rtl/display_bcd_feeder.sv | 138 +++++++++++++
 tb/tb_display_bcd_feeder.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/display_bcd_feeder_if.sv
// ---------------------------------------------------------------------------
// display_bcd_feeder_if : MMIO bus between the CPU and the digit source. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface display_bcd_feeder_if;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (
    output wr_en,
    output rd_en,
    output addr,
    output wdata,
    input  rdata
  );

  modport slave (
    input  wr_en,
    input  rd_en,
    input  addr,
    input  wdata,
    output rdata
  );
endinterface

`default_nettype wire

// File: rtl/display_bcd_feeder.sv
// ---------------------------------------------------------------------------
// display_bcd_feeder : MMIO value -> eight hex or decimal digit codes. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module display_bcd_feeder #(
  parameter logic [31:0] ADDR_DATA = 32'hFFFF_FC60,
  parameter logic [31:0] ADDR_MODE = 32'hFFFF_FC64,
  parameter logic [31:0] ADDR_STAT = 32'hFFFF_FC68,
  parameter logic [31:0] DEC_MAX   = 32'd99_999_999
) (
  input  logic                       clk,
  input  logic                       rst,
  display_bcd_feeder_if.slave        bus,
  output logic                       busy,
  output logic [3:0]                 s1,
  output logic [3:0]                 s2,
  output logic [3:0]                 s3,
  output logic [3:0]                 s4,
  output logic [3:0]                 s5,
  output logic [3:0]                 s6,
  output logic [3:0]                 s7,
  output logic [3:0]                 s8
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] value_reg;
  logic        mode_reg;
  logic [31:0] shift_reg;
  logic [31:0] bcd_reg;
  logic [4:0]  step_cnt;

  logic        hit_data;
  logic        hit_mode;
  logic        accept;
  logic [31:0] next_value;
  logic        next_mode;
  logic [31:0] sat_value;
  logic [31:0] bcd_adj;
  logic        unused_rd;

  // Reads are side-effect free, so the read strobe is not needed.
  assign unused_rd = bus.rd_en;

  assign hit_data   = bus.wr_en && (bus.addr == ADDR_DATA);
  assign hit_mode   = bus.wr_en && (bus.addr == ADDR_MODE);
  assign accept     = hit_data || hit_mode;
  assign next_value = hit_data ? bus.wdata : value_reg;
  assign next_mode  = hit_mode ? bus.wdata[0] : mode_reg;
  assign sat_value  = (next_value > DEC_MAX) ? DEC_MAX : next_value;

  always_comb begin
    bcd_adj = bcd_reg;
    for (int i = 0; i < 8; i++) begin
      if (bcd_reg[i*4 +: 4] >= 4'd5) begin
        bcd_adj[i*4 +: 4] = bcd_reg[i*4 +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    bus.rdata = 32'd0;
    if (bus.addr == ADDR_DATA) begin
      bus.rdata = value_reg;
    end else if (bus.addr == ADDR_MODE) begin
      bus.rdata = {31'd0, mode_reg};
    end else if (bus.addr == ADDR_STAT) begin
      bus.rdata = {31'd0, busy};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      value_reg <= 32'd0;
      mode_reg  <= 1'b0;
      shift_reg <= 32'd0;
      bcd_reg   <= 32'd0;
      step_cnt  <= 5'd0;
      busy      <= 1'b0;
      {s1, s2, s3, s4, s5, s6, s7, s8} <= 32'd0;
    end else begin
      if (hit_data) begin
        value_reg <= bus.wdata;
      end
      if (hit_mode) begin
        mode_reg <= bus.wdata[0];
      end

      // A new write always wins over any conversion in flight.
      if (accept) begin
        if (!next_mode) begin
          {s1, s2, s3, s4, s5, s6, s7, s8} <= next_value;
          busy  <= 1'b0;
          state <= IDLE;
        end else begin
          shift_reg <= sat_value;
          bcd_reg   <= 32'd0;
          step_cnt  <= 5'd0;
          busy      <= 1'b1;
          state     <= CONV;
        end
      end else begin
        case (state)
          CONV: begin
            bcd_reg   <= {bcd_adj[30:0], shift_reg[31]};
            shift_reg <= {shift_reg[30:0], 1'b0};
            step_cnt  <= step_cnt + 5'd1;
            if (step_cnt == 5'd31) begin
              state <= DONE;
            end
          end
          DONE: begin
            {s1, s2, s3, s4, s5, s6, s7, s8} <= bcd_reg;
            busy  <= 1'b0;
            state <= IDLE;
          end
          IDLE: begin
            busy <= 1'b0;
          end
          default: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_display_bcd_feeder.sv
// Directed self-checking bench for display_bcd_feeder.
`default_nettype none

module tb_display_bcd_feeder;

  localparam logic [31:0] A_DATA = 32'hFFFF_FC60;
  localparam logic [31:0] A_MODE = 32'hFFFF_FC64;
  localparam logic [31:0] A_STAT = 32'hFFFF_FC68;
  localparam logic [31:0] A_NONE = 32'hFFFF_FC6C;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  logic [3:0] s1, s2, s3, s4, s5, s6, s7, s8;
  wire  [31:0] digits = {s1, s2, s3, s4, s5, s6, s7, s8};

  int vectors = 0;
  int miscompares = 0;
  logic watch5 = 1'b0;
  logic seen5  = 1'b0;

  always #5 clk = ~clk;

  display_bcd_feeder_if bus ();

  display_bcd_feeder dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy),
    .s1   (s1),
    .s2   (s2),
    .s3   (s3),
    .s4   (s4),
    .s5   (s5),
    .s6   (s6),
    .s7   (s7),
    .s8   (s8)
  );

  always @(negedge clk) begin
    if (watch5 && digits == 32'h0000_0005) seen5 = 1'b1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic write_reg(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.addr  = a;
    bus.wdata = d;
    bus.wr_en = 1'b1;
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  task automatic read_reg(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.addr  = a;
    bus.rd_en = 1'b1;
    #1;
    d = bus.rdata;
    bus.rd_en = 1'b0;
  endtask

  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (busy === 1'b1 && cycles < 200) begin
      cycles++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    logic [31:0] r;
    rst = 1'b0;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    bus.addr  = 32'd0;
    bus.wdata = 32'd0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if (digits !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_digits: got %h expected %h", digits, 32'd0);
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_busy: got %b expected 0", busy);
    end
    read_reg(A_MODE, r);
    vectors++;
    if (r !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_mode_read: got %h expected %h", r, 32'd0);
    end
  endtask

  task automatic test_hex();
    logic [31:0] r;
    logic busy_seen;
    write_reg(A_DATA, 32'h1234_ABCD);
    busy_seen = busy;
    vectors++;
    if (digits !== 32'h1234_ABCD) begin
      miscompares++;
      $display("FAIL hex_digits: got %h expected %h", digits, 32'h1234_ABCD);
    end
    repeat (4) begin
      @(negedge clk);
      if (busy !== 1'b0) busy_seen = 1'b1;
    end
    vectors++;
    if (busy_seen !== 1'b0) begin
      miscompares++;
      $display("FAIL hex_busy: got %b expected 0", busy_seen);
    end
    read_reg(A_DATA, r);
    vectors++;
    if (r !== 32'h1234_ABCD) begin
      miscompares++;
      $display("FAIL read_data: got %h expected %h", r, 32'h1234_ABCD);
    end
    read_reg(A_STAT, r);
    vectors++;
    if (r !== 32'd0) begin
      miscompares++;
      $display("FAIL read_stat_idle: got %h expected %h", r, 32'd0);
    end
    write_reg(A_NONE, 32'hDEAD_BEEF);
    read_reg(A_NONE, r);
    vectors++;
    if (r !== 32'd0) begin
      miscompares++;
      $display("FAIL read_unmapped: got %h expected %h", r, 32'd0);
    end
    vectors++;
    if (digits !== 32'h1234_ABCD) begin
      miscompares++;
      $display("FAIL ignored_write_digits: got %h expected %h", digits, 32'h1234_ABCD);
    end
  endtask

  task automatic test_decimal();
    logic [31:0] r;
    int cnt;
    logic held_bad;
    write_reg(A_MODE, 32'd1);
    write_reg(A_DATA, 32'd12345678);
    read_reg(A_STAT, r);
    vectors++;
    if (r !== 32'd1) begin
      miscompares++;
      $display("FAIL read_stat_busy: got %h expected %h", r, 32'd1);
    end
    // read_reg consumed one negedge of the busy window
    cnt = 1;
    held_bad = 1'b0;
    while (busy === 1'b1 && cnt < 200) begin
      if (digits !== 32'h1234_ABCD) held_bad = 1'b1;
      cnt++;
      @(negedge clk);
    end
    vectors++;
    if (cnt !== 33) begin
      miscompares++;
      $display("FAIL dec_busy_len: got %0d expected 33", cnt);
    end
    vectors++;
    if (held_bad !== 1'b0) begin
      miscompares++;
      $display("FAIL dec_hold_prev: got changed expected held %h", 32'h1234_ABCD);
    end
    vectors++;
    if (digits !== 32'h1234_5678) begin
      miscompares++;
      $display("FAIL dec_digits: got %h expected %h", digits, 32'h1234_5678);
    end
    read_reg(A_MODE, r);
    vectors++;
    if (r !== 32'd1) begin
      miscompares++;
      $display("FAIL read_mode_dec: got %h expected %h", r, 32'd1);
    end
  endtask

  task automatic test_saturation();
    logic [31:0] vin [5];
    logic [31:0] vexp [5];
    int cnt;
    vin[0] = 32'hFFFF_FFFF;   vexp[0] = 32'h9999_9999;
    vin[1] = 32'd100_000_000; vexp[1] = 32'h9999_9999;
    vin[2] = 32'd99_999_999;  vexp[2] = 32'h9999_9999;
    vin[3] = 32'd99_999_998;  vexp[3] = 32'h9999_9998;
    vin[4] = 32'd0;           vexp[4] = 32'h0000_0000;
    for (int i = 0; i < 5; i++) begin
      write_reg(A_DATA, vin[i]);
      wait_idle(cnt);
      vectors++;
      if (cnt !== 33) begin
        miscompares++;
        $display("FAIL sat_busy_len[%0d]: got %0d expected 33", i, cnt);
      end
      vectors++;
      if (digits !== vexp[i]) begin
        miscompares++;
        $display("FAIL sat_digits[%0d]: got %h expected %h", i, digits, vexp[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int cnt;
    seen5  = 1'b0;
    watch5 = 1'b1;
    write_reg(A_DATA, 32'd5);
    repeat (9) @(negedge clk);
    write_reg(A_DATA, 32'd42);
    wait_idle(cnt);
    repeat (3) @(negedge clk);
    watch5 = 1'b0;
    vectors++;
    if (cnt !== 33) begin
      miscompares++;
      $display("FAIL b2b_busy_len: got %0d expected 33", cnt);
    end
    vectors++;
    if (digits !== 32'h0000_0042) begin
      miscompares++;
      $display("FAIL b2b_digits: got %h expected %h", digits, 32'h0000_0042);
    end
    vectors++;
    if (seen5 !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_no_five: got %b expected 0", seen5);
    end
  endtask

  task automatic test_mode_abort();
    write_reg(A_DATA, 32'd87654321);
    repeat (5) @(negedge clk);
    write_reg(A_MODE, 32'd0);
    vectors++;
    if (busy !== 1'b0 || digits !== 32'h0539_7FB1) begin
      miscompares++;
      $display("FAIL abort_to_hex: got busy=%b digits=%h expected busy=0 digits=%h",
               busy, digits, 32'h0539_7FB1);
    end
    repeat (40) @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || digits !== 32'h0539_7FB1) begin
      miscompares++;
      $display("FAIL abort_no_late_done: got busy=%b digits=%h expected busy=0 digits=%h",
               busy, digits, 32'h0539_7FB1);
    end
  endtask

  task automatic test_reset_mid_conv();
    logic [31:0] r;
    write_reg(A_MODE, 32'd1);
    write_reg(A_DATA, 32'd87654321);
    repeat (19) @(negedge clk);
    vectors++;
    if (busy !== 1'b1 || digits !== 32'h0539_7FB1) begin
      miscompares++;
      $display("FAIL midconv_state: got busy=%b digits=%h expected busy=1 digits=%h",
               busy, digits, 32'h0539_7FB1);
    end
    rst = 1'b0;
    #1;
    vectors++;
    if (busy !== 1'b0 || digits !== 32'd0) begin
      miscompares++;
      $display("FAIL async_reset: got busy=%b digits=%h expected busy=0 digits=%h",
               busy, digits, 32'd0);
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    read_reg(A_DATA, r);
    vectors++;
    if (r !== 32'd0) begin
      miscompares++;
      $display("FAIL post_reset_value: got %h expected %h", r, 32'd0);
    end
    read_reg(A_MODE, r);
    vectors++;
    if (r !== 32'd0) begin
      miscompares++;
      $display("FAIL post_reset_mode: got %h expected %h", r, 32'd0);
    end
    repeat (40) @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || digits !== 32'd0) begin
      miscompares++;
      $display("FAIL post_reset_quiet: got busy=%b digits=%h expected busy=0 digits=%h",
               busy, digits, 32'd0);
    end
  endtask

  initial begin
    test_reset();
    test_hex();
    test_decimal();
    test_saturation();
    test_back_to_back();
    test_mode_abort();
    test_reset_mid_conv();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
